// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared state encoding and index-width helpers for the row-stationary PE
package pe_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_W,
        S_MAC,
        S_PSUM,
        S_EMIT,
        S_DONE
    } pe_state_e;

    // Width of an index into n entries, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IACT_LEN_DEF = 5;
    localparam int KER_LEN_DEF  = 3;
    localparam int STRIDE_DEF   = 1;
    localparam int OUT_LEN_DEF  = (IACT_LEN_DEF - KER_LEN_DEF) / STRIDE_DEF + 1;
    localparam int IACT_IDX_W   = idx_w(IACT_LEN_DEF);
    localparam int KER_IDX_W    = idx_w(KER_LEN_DEF);
    localparam int OUT_IDX_W    = idx_w(OUT_LEN_DEF);

endpackage

// File: rtl/pe_row_conv_if.sv
// rtl/pe_row_conv_if.sv - control and valid/ready data bundle between PE and its feeders
interface pe_row_conv_if #(
    parameter int D_WIDTH   = 16,
    parameter int ACC_WIDTH = 32
);
    logic                 start;
    logic                 acc_psum;
    logic                 keep_weight;
    logic                 iact_valid;
    logic                 iact_ready;
    logic [D_WIDTH-1:0]   iact_data;
    logic                 w_valid;
    logic                 w_ready;
    logic [D_WIDTH-1:0]   w_data;
    logic                 psum_in_valid;
    logic                 psum_in_ready;
    logic [ACC_WIDTH-1:0] psum_in_data;
    logic                 psum_out_valid;
    logic                 psum_out_ready;
    logic [ACC_WIDTH-1:0] psum_out_data;
    logic                 busy;
    logic                 done;

    modport master (
        output start, acc_psum, keep_weight,
        output iact_valid, iact_data, input iact_ready,
        output w_valid, w_data, input w_ready,
        output psum_in_valid, psum_in_data, input psum_in_ready,
        input psum_out_valid, psum_out_data, output psum_out_ready,
        input busy, done
    );

    modport slave (
        input start, acc_psum, keep_weight,
        input iact_valid, iact_data, output iact_ready,
        input w_valid, w_data, output w_ready,
        input psum_in_valid, psum_in_data, output psum_in_ready,
        output psum_out_valid, psum_out_data, input psum_out_ready,
        output busy, done
    );
endinterface

// File: rtl/pe_spad_rf.sv
// rtl/pe_spad_rf.sv - scratchpad register file, one sync write port and one async read port
module pe_spad_rf
    import pe_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [idx_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [idx_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pe_row_conv.sv
// rtl/pe_row_conv.sv - row-stationary PE: buffers an iact row and a kernel row, then
// runs a strided 1-D convolution with one signed MAC per cycle and optional psum add
module pe_row_conv
    import pe_pkg::*;
#(
    parameter int D_WIDTH   = 16,
    parameter int ACC_WIDTH = 32,
    parameter int IACT_LEN  = 5,
    parameter int KER_LEN   = 3,
    parameter int STRIDE    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    pe_row_conv_if.slave bus
);
    localparam int OUT_LEN = (IACT_LEN - KER_LEN) / STRIDE + 1;
    localparam int IW      = idx_w(IACT_LEN);
    localparam int KW      = idx_w(KER_LEN);
    localparam int OW      = idx_w(OUT_LEN);

    if (KER_LEN > IACT_LEN || ACC_WIDTH < 2 * D_WIDTH) begin : g_param_check
        $error("pe_row_conv: KER_LEN must be <= IACT_LEN and ACC_WIDTH >= 2*D_WIDTH");
    end

    pe_state_e                    state;
    logic                         acc_psum_q;
    logic                         keep_q;
    logic                         w_held;
    logic [IW-1:0]                ld_idx;
    logic [KW-1:0]                k;
    logic [OW-1:0]                out_idx;
    logic signed [ACC_WIDTH-1:0]  acc;

    logic [D_WIDTH-1:0]           iact_rd;
    logic [D_WIDTH-1:0]           w_rd;
    logic [IW-1:0]                iact_raddr;
    logic signed [2*D_WIDTH-1:0]  prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;

    assign iact_raddr = IW'(int'(out_idx) * STRIDE + int'(k));

    pe_spad_rf #(.DEPTH(IACT_LEN), .WIDTH(D_WIDTH)) iact_spad (
        .clk   (clk),
        .we    (state == S_LOAD_I && bus.iact_valid),
        .waddr (ld_idx),
        .wdata (bus.iact_data),
        .raddr (iact_raddr),
        .rdata (iact_rd)
    );

    pe_spad_rf #(.DEPTH(KER_LEN), .WIDTH(D_WIDTH)) w_spad (
        .clk   (clk),
        .we    (state == S_LOAD_W && bus.w_valid),
        .waddr (KW'(ld_idx)),
        .wdata (bus.w_data),
        .raddr (k),
        .rdata (w_rd)
    );

    assign prod     = $signed(iact_rd) * $signed(w_rd);
    assign prod_ext = ACC_WIDTH'(prod);

    // Handshake outputs depend on the registered state only.
    assign bus.iact_ready     = (state == S_LOAD_I);
    assign bus.w_ready        = (state == S_LOAD_W);
    assign bus.psum_in_ready  = (state == S_PSUM);
    assign bus.psum_out_valid = (state == S_EMIT);
    assign bus.psum_out_data  = acc;
    assign bus.busy           = (state != S_IDLE);
    assign bus.done           = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            acc_psum_q <= 1'b0;
            keep_q     <= 1'b0;
            w_held     <= 1'b0;
            ld_idx     <= '0;
            k          <= '0;
            out_idx    <= '0;
            acc        <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    acc_psum_q <= bus.acc_psum;
                    keep_q     <= bus.keep_weight;
                    out_idx    <= '0;
                    ld_idx     <= '0;
                    state      <= S_LOAD_I;
                end
                S_LOAD_I: if (bus.iact_valid) begin
                    ld_idx <= ld_idx + 1'b1;
                    if (ld_idx == IW'(IACT_LEN - 1)) begin
                        ld_idx <= '0;
                        k      <= '0;
                        state  <= (keep_q && w_held) ? S_MAC : S_LOAD_W;
                    end
                end
                S_LOAD_W: if (bus.w_valid) begin
                    ld_idx <= ld_idx + 1'b1;
                    if (ld_idx == IW'(KER_LEN - 1)) begin
                        ld_idx <= '0;
                        k      <= '0;
                        w_held <= 1'b1;
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= (k == '0) ? prod_ext : acc + prod_ext;
                    k   <= k + 1'b1;
                    if (k == KW'(KER_LEN - 1)) begin
                        k     <= '0;
                        state <= acc_psum_q ? S_PSUM : S_EMIT;
                    end
                end
                S_PSUM: if (bus.psum_in_valid) begin
                    acc   <= acc + $signed(bus.psum_in_data);
                    state <= S_EMIT;
                end
                S_EMIT: if (bus.psum_out_ready) begin
                    if (out_idx == OW'(OUT_LEN - 1)) begin
                        state <= S_DONE;
                    end else begin
                        out_idx <= out_idx + 1'b1;
                        state   <= S_MAC;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_row_conv.sv
// tb/tb_pe_row_conv.sv - directed-vector bench for pe_row_conv (default and stride-2 instances)
module tb_pe_row_conv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_row_conv_if #(.D_WIDTH(16), .ACC_WIDTH(32)) ifa ();
    pe_row_conv_if #(.D_WIDTH(16), .ACC_WIDTH(32)) ifb ();

    pe_row_conv #(.D_WIDTH(16), .ACC_WIDTH(32), .IACT_LEN(5), .KER_LEN(3), .STRIDE(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    pe_row_conv #(.D_WIDTH(16), .ACC_WIDTH(32), .IACT_LEN(7), .KER_LEN(3), .STRIDE(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    logic        sel = 1'b0;
    logic        t_start = 0, t_acc = 0, t_keep = 0, t_iv = 0, t_wv = 0, t_pv = 0, t_or = 1;
    logic [15:0] t_id = '0, t_wd = '0;
    logic [31:0] t_pd = '0;

    assign ifa.start = t_start & ~sel;          assign ifb.start = t_start & sel;
    assign ifa.acc_psum = t_acc;                assign ifb.acc_psum = t_acc;
    assign ifa.keep_weight = t_keep;            assign ifb.keep_weight = t_keep;
    assign ifa.iact_valid = t_iv & ~sel;        assign ifb.iact_valid = t_iv & sel;
    assign ifa.iact_data = t_id;                assign ifb.iact_data = t_id;
    assign ifa.w_valid = t_wv & ~sel;           assign ifb.w_valid = t_wv & sel;
    assign ifa.w_data = t_wd;                   assign ifb.w_data = t_wd;
    assign ifa.psum_in_valid = t_pv & ~sel;     assign ifb.psum_in_valid = t_pv & sel;
    assign ifa.psum_in_data = t_pd;             assign ifb.psum_in_data = t_pd;
    assign ifa.psum_out_ready = t_or;           assign ifb.psum_out_ready = t_or;

    wire        m_ir   = sel ? ifb.iact_ready     : ifa.iact_ready;
    wire        m_wr   = sel ? ifb.w_ready        : ifa.w_ready;
    wire        m_pr   = sel ? ifb.psum_in_ready  : ifa.psum_in_ready;
    wire        m_ov   = sel ? ifb.psum_out_valid : ifa.psum_out_valid;
    wire [31:0] m_od   = sel ? ifb.psum_out_data  : ifa.psum_out_data;
    wire        m_busy = sel ? ifb.busy           : ifa.busy;
    wire        m_done = sel ? ifb.done           : ifa.done;

    int n_vec = 0;
    int n_bad = 0;

    logic mon_w = 1'b0;
    logic saw_wr = 1'b0;
    always @(negedge clk) if (mon_w && m_wr) saw_wr <= 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0: return m_ir;
            1: return m_wr;
            2: return m_pr;
            default: return m_ov;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string tag);
        int t = 0;
        while (sig(which) !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sig(which) !== 1'b1) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send_beats(input bit is_w, input int vals[$]);
        foreach (vals[i]) begin
            if (is_w) begin t_wv = 1; t_wd = 16'(vals[i]); end
            else      begin t_iv = 1; t_id = 16'(vals[i]); end
            wait_sig(is_w ? 1 : 0, is_w ? "w_load" : "iact_load");
            @(negedge clk);
        end
        if (is_w) t_wv = 0; else t_iv = 0;
    endtask

    task automatic get_out(input string tag, input logic [31:0] exp);
        t_or = 1;
        wait_sig(3, tag);
        check(tag, m_od, exp);
        @(negedge clk);
    endtask

    // wr_chk: 0/1 = expected w_ready right after the iact row, 2 = skip.
    // stall: 1 = hold psum_out_ready low on first output, 2 = withhold first psum_in.
    task automatic run(input string tag, input bit acc, input bit keep, input int iact[$],
                       input int w[$], input int pin[$], input int exps[$],
                       input int wr_chk, input int stall);
        logic [31:0] held;
        bit ok;
        @(negedge clk);
        t_acc = acc; t_keep = keep; t_start = 1;
        @(negedge clk);
        t_start = 0;
        send_beats(0, iact);
        if (wr_chk != 2) check({tag, "_w_ready"}, 32'(m_wr), 32'(wr_chk));
        if (w.size() > 0) send_beats(1, w);
        foreach (exps[j]) begin
            if (acc) begin
                wait_sig(2, {tag, "_psum_in"});
                if (stall == 2 && j == 0) begin
                    ok = 1;
                    repeat (4) begin
                        @(negedge clk);
                        if (m_ov !== 1'b0 || m_pr !== 1'b1) ok = 0;
                    end
                    check({tag, "_psum_stall"}, 32'(ok), 32'd1);
                end
                t_pv = 1; t_pd = 32'(pin[j]);
                @(negedge clk);
                t_pv = 0;
            end
            if (stall == 1 && j == 0) begin
                t_or = 0;
                wait_sig(3, {tag, "_emit"});
                held = m_od;
                ok = 1;
                repeat (5) begin
                    t_start = 1;
                    @(negedge clk);
                    if (m_ov !== 1'b1 || m_od !== held) ok = 0;
                end
                t_start = 0;
                check({tag, "_emit_stable"}, 32'(ok), 32'd1);
            end
            get_out($sformatf("%s_out%0d", tag, j), 32'(exps[j]));
        end
        check({tag, "_done"}, 32'(m_done), 32'd1);
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, m_done, m_busy}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy_done", {30'd0, m_busy, m_done}, 32'd0);
        check("rst_readies", {29'd0, m_ir, m_wr, m_pr}, 32'd0);
        check("rst_out_valid", 32'(m_ov), 32'd0);
        check("rst_out_data", m_od, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("basic", 0, 0, '{1, 2, 3, 4, 5}, '{1, 0, -1}, '{}, '{-2, -2, -2}, 1, 1);
        run("psum", 1, 0, '{1, 2, 3, 4, 5}, '{1, 0, -1}, '{10, 20, 30}, '{8, 18, 28}, 2, 2);

        mon_w = 1; saw_wr = 0; t_wv = 1; t_wd = 16'h7777;
        run("keep", 0, 1, '{5, 4, 3, 2, 1}, '{}, '{}, '{2, 2, 2}, 0, 0);
        mon_w = 0; t_wv = 0;
        check("keep_no_w_ready", 32'(saw_wr), 32'd0);

        run("wrap", 0, 0, '{-32768, -32768, -32768, -32768, -32768}, '{-32768, -32768, -32768},
            '{}, '{32'hC000_0000, 32'hC000_0000, 32'hC000_0000}, 2, 0);

        sel = 1;
        run("stride2", 0, 0, '{0, 1, 2, 3, 4, 5, 6}, '{1, 1, 1}, '{}, '{3, 9, 15}, 1, 0);
        sel = 0;

        @(negedge clk);
        t_keep = 1; t_acc = 0; t_start = 1;
        @(negedge clk);
        t_start = 0;
        send_beats(0, '{1, 2, 3, 4, 5});
        check("pre_rst_in_mac", 32'(m_busy && !m_wr && !m_ir), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy_done", {30'd0, m_busy, m_done}, 32'd0);
        check("midrst_out", {m_od[30:0], m_ov}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_rst", 0, 1, '{1, 2, 3, 4, 5}, '{1, 0, -1}, '{}, '{-2, -2, -2}, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
